// File: rtl/draw_tank.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | draw_tank : 3-stage VGA sprite overlay (48x64 tank over background video).  |
// | Optional: define DRAW_TANK_TRANSPARENCY_EN to treat KEY_COLOR as see-thru.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module draw_tank #(
  parameter logic [10:0] XPOS_RST  = 11'd100,
  parameter logic [10:0] YPOS_RST  = 11'd100,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [11:0] c_SPRITE_W = 12'd48;
  localparam logic [11:0] c_SPRITE_H = 12'd64;

  logic        vblnk_prev_q;
  logic [10:0] xpos_l_q, ypos_l_q;

  logic        inside1_q, inside2_q;
  logic [10:0] hcount1_q, vcount1_q, hcount2_q, vcount2_q;
  logic [3:0]  tim1_q, tim2_q;   // {hsync, hblnk, vsync, vblnk}
  logic [11:0] rgb1_q, rgb2_q;

  logic        inside_d;
  logic [11:0] h_ext, v_ext, xl_ext, yl_ext;
  logic [5:0]  x_lo, y_lo;
  logic [11:0] rom_addr_d;
  logic        show_sprite;
  logic [11:0] rgb_d;
  logic        vblnk_rise;

  always_comb begin
    h_ext  = {1'b0, hcount_in};
    v_ext  = {1'b0, vcount_in};
    xl_ext = {1'b0, xpos_l_q};
    yl_ext = {1'b0, ypos_l_q};
    inside_d = (h_ext >= xl_ext) && (h_ext < xl_ext + c_SPRITE_W) &&
               (v_ext >= yl_ext) && (v_ext < yl_ext + c_SPRITE_H);
    // Only the low six bits of the local offset reach the ROM address.
    x_lo = hcount_in[5:0] - xpos_l_q[5:0];
    y_lo = vcount_in[5:0] - ypos_l_q[5:0];
    rom_addr_d = inside_d ? {y_lo, x_lo} : 12'h000;
    vblnk_rise = vblnk_in & ~vblnk_prev_q;
`ifdef DRAW_TANK_TRANSPARENCY_EN
    show_sprite = inside2_q && (rom_rgb != KEY_COLOR);
`else
    show_sprite = inside2_q;
`endif
    if (tim2_q[2] || tim2_q[0])
      rgb_d = 12'h000;
    else if (show_sprite)
      rgb_d = rom_rgb;
    else
      rgb_d = rgb2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      xpos_l_q     <= XPOS_RST;
      ypos_l_q     <= YPOS_RST;
      rom_addr     <= 12'h000;
      inside1_q    <= 1'b0;
      hcount1_q    <= '0;
      vcount1_q    <= '0;
      tim1_q       <= '0;
      rgb1_q       <= '0;
      inside2_q    <= 1'b0;
      hcount2_q    <= '0;
      vcount2_q    <= '0;
      tim2_q       <= '0;
      rgb2_q       <= '0;
      hcount_out   <= '0;
      vcount_out   <= '0;
      hsync_out    <= 1'b0;
      hblnk_out    <= 1'b0;
      vsync_out    <= 1'b0;
      vblnk_out    <= 1'b0;
      rgb_out      <= '0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      // Position only moves at the start of vertical blanking.
      if (vblnk_rise) begin
        xpos_l_q <= xpos;
        ypos_l_q <= ypos;
      end
      rom_addr   <= rom_addr_d;
      inside1_q  <= inside_d;
      hcount1_q  <= hcount_in;
      vcount1_q  <= vcount_in;
      tim1_q     <= {hsync_in, hblnk_in, vsync_in, vblnk_in};
      rgb1_q     <= rgb_in;
      inside2_q  <= inside1_q;
      hcount2_q  <= hcount1_q;
      vcount2_q  <= vcount1_q;
      tim2_q     <= tim1_q;
      rgb2_q     <= rgb1_q;
      hcount_out <= hcount2_q;
      vcount_out <= vcount2_q;
      hsync_out  <= tim2_q[3];
      hblnk_out  <= tim2_q[2];
      vsync_out  <= tim2_q[1];
      vblnk_out  <= tim2_q[0];
      rgb_out    <= rgb_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_tank.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_draw_tank : directed vectors with queued expectations for draw_tank.    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_draw_tank;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, xpos, ypos;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in, rom_addr, rom_rgb;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

`ifdef DRAW_TANK_TRANSPARENCY_EN
  localparam int TRANSP = 'h0A0;
`else
  localparam int TRANSP = 'hF0F;
`endif

  draw_tank dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Synchronous image ROM: contents are address XOR 5A5.
  initial rom_rgb = 12'h000;
  always @(posedge clk) rom_rgb <= rom_addr ^ 12'h5A5;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [11:0] addr;
  } a_t;
  typedef struct {
    int          due;
    logic [10:0] h;
    logic [10:0] v;
    logic [3:0]  tim;
    logic [11:0] rgb;
  } o_t;

  a_t aq[$];
  o_t oq[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic drive(input int h, input int v, input int tim, input int rgb,
                       input int xp, input int yp, input int exp_rgb,
                       input int exp_addr, input bit push);
    a_t a;
    o_t o;
    @(posedge clk);
    #1;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    {hsync_in, hblnk_in, vsync_in, vblnk_in} = 4'(tim);
    rgb_in = 12'(rgb);
    xpos   = 11'(xp);
    ypos   = 11'(yp);
    if (push) begin
      a.due  = cyc + 1;
      a.addr = 12'(exp_addr);
      aq.push_back(a);
      o.due  = cyc + 3;
      o.h    = 11'(h);
      o.v    = 11'(v);
      o.tim  = 4'(tim);
      o.rgb  = 12'(exp_rgb);
      oq.push_back(o);
    end
  endtask

  task automatic check_reset(input string name);
    logic [49:0] got;
    got = {rom_addr, rgb_out, hcount_out, vcount_out,
           hsync_out, hblnk_out, vsync_out, vblnk_out};
    n_vec++;
    if (got !== 50'd0) begin
      n_err++;
      $display("FAIL %s: outputs got %h expected all zero", name, got);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && (aq.size() != 0 || oq.size() != 0); i++)
      @(negedge clk);
    if (aq.size() != 0 || oq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left expected 0", aq.size() + oq.size());
    end
  endtask

  // Monitor: pops expectations as their output cycle arrives.
  initial begin
    a_t a;
    o_t o;
    forever begin
      @(negedge clk);
      while (aq.size() != 0 && aq[0].due <= cyc) begin
        a = aq.pop_front();
        n_vec++;
        if (a.due != cyc || rom_addr !== a.addr) begin
          n_err++;
          $display("FAIL rom_addr due %0d at %0d: got %h expected %h",
                   a.due, cyc, rom_addr, a.addr);
        end
      end
      while (oq.size() != 0 && oq[0].due <= cyc) begin
        o = oq.pop_front();
        n_vec++;
        if (o.due != cyc || rgb_out !== o.rgb || hcount_out !== o.h ||
            vcount_out !== o.v ||
            {hsync_out, hblnk_out, vsync_out, vblnk_out} !== o.tim) begin
          n_err++;
          $display("FAIL outputs due %0d at %0d: got rgb=%h h=%0d v=%0d tim=%b expected rgb=%h h=%0d v=%0d tim=%b",
                   o.due, cyc, rgb_out, hcount_out, vcount_out,
                   {hsync_out, hblnk_out, vsync_out, vblnk_out},
                   o.rgb, o.h, o.v, o.tim);
        end
      end
    end
  end

  // tim argument order: {hsync, hblnk, vsync, vblnk}
  initial begin
    rst = 1'b1;
    hcount_in = 11'd101; vcount_in = 11'd101;
    {hsync_in, hblnk_in, vsync_in, vblnk_in} = 4'b1010;
    rgb_in = 12'hFFF; xpos = 11'd5; ypos = 11'd100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Before the first vblnk rise the reset position (100,100) is in force.
    drive(101, 101, 4'b0000, 'h123,   5, 100, 'h5E4, 'h041, 1);
    drive(  6, 101, 4'b0000, 'h0A0,   5, 100, 'h0A0, 'h000, 1);
    drive(500, 300, 4'b0010, 'h123,   5, 100, 'h123, 'h000, 1);
    drive(  0, 480, 4'b0001, 'hFFF,   5, 100, 'h000, 'h000, 1);
    drive(  1, 481, 4'b1101, 'hFFF,   5, 100, 'h000, 'h000, 1);
    drive(  6, 101, 4'b0000, 'h0A0,   5, 100, 'h5E4, 'h041, 1);
    drive(101, 101, 4'b0000, 'h0A0,   5, 100, 'h0A0, 'h000, 1);
    // Mid-frame move request must be ignored.
    drive(  6, 101, 4'b0000, 'h0A0, 300, 100, 'h5E4, 'h041, 1);
    drive(300, 101, 4'b0000, 'h0A0, 300, 100, 'h0A0, 'h000, 1);
    // Change coincident with the vblnk rise is adopted.
    drive(  0, 480, 4'b0001, 'hFFF, 100, 100, 'h000, 'h000, 1);
    drive(147, 163, 4'b0000, 'h321, 100, 100, 'hA4A, 'hFEF, 1);
    drive(148, 163, 4'b0000, 'h321, 100, 100, 'h321, 'h000, 1);
    drive(147, 164, 4'b0000, 'h321, 100, 100, 'h321, 'h000, 1);
    drive(100, 100, 4'b0000, 'h456, 100, 100, 'h5A5, 'h000, 1);
    drive( 99, 100, 4'b0000, 'h456, 100, 100, 'h456, 'h000, 1);
    drive(142, 142, 4'b0000, 'h0A0, 100, 100, TRANSP, 'hAAA, 1);
    drive(101, 101, 4'b0100, 'h0A0, 100, 100, 'h000, 'h041, 1);
    // Clipping at the right edge.
    drive(   0, 480, 4'b0001, 'hFFF, 2030, 100, 'h000, 'h000, 1);
    drive(2047, 101, 4'b0000, 'h789, 2030, 100, 'h5F4, 'h051, 1);
    drive(2030, 100, 4'b0000, 'h789, 2030, 100, 'h5A5, 'h000, 1);
    drive(   0, 101, 4'b0000, 'h789, 2030, 100, 'h789, 'h000, 1);
    drive(  29, 101, 4'b0000, 'h789, 2030, 100, 'h789, 'h000, 1);
    drive(2029, 101, 4'b0000, 'h789, 2030, 100, 'h789, 'h000, 1);
    drive(  10,  10, 4'b0000, 'h000, 2030, 100, 'h000, 'h000, 0);
    wait_drain();

    // Mid-frame reset flushes the pipeline and restores the reset position.
    drive(10, 10, 4'b1010, 'hABC, 2030, 100, 'h000, 'h000, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("mid_reset");
    rst = 1'b0;
    drive(101, 101, 4'b0000, 'h123, 2030, 100, 'h5E4, 'h041, 1);
    drive( 10,  10, 4'b0000, 'h000, 2030, 100, 'h000, 'h000, 0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/draw_tank.md
DRAW_TANK -- requirements
Module: draw_tank

Interface
REQ-001 SHALL have parameter XPOS_RST, default 11'd100, meaning sprite X position after reset.
REQ-002 SHALL have parameter YPOS_RST, default 11'd100, meaning sprite Y position after reset.
REQ-003 SHALL have parameter KEY_COLOR, default 12'hF0F, meaning transparent colour in the sprite image.
REQ-004 SHALL have port clk, input, 1, the single system (pixel) clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have ports hcount_in and vcount_in, input, 11 each, the incoming VGA pixel coordinates.
REQ-007 SHALL have ports hsync_in, hblnk_in, vsync_in and vblnk_in, input, 1 each, the incoming timing strobes.
REQ-008 SHALL have port rgb_in, input, 12, the background pixel {r,g,b}, 4 bits each.
REQ-009 SHALL have ports xpos and ypos, input, 11 each, the requested sprite top-left corner.
REQ-010 SHALL have port rom_addr, output, 12, image ROM address {y[5:0], x[5:0]}.
REQ-011 SHALL have port rom_rgb, input, 12, image ROM data, valid one clk after rom_addr.
REQ-012 SHALL have ports hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out and vblnk_out, output, widths matching the inputs, the delayed timing.
REQ-013 SHALL have port rgb_out, output, 12, the composited pixel.

Function
REQ-014 Sprite size SHALL be 48 wide x 64 high; local x = hcount_in - xpos_l and local y = vcount_in - ypos_l.
REQ-015 xpos_l/ypos_l SHALL load from xpos/ypos only in the cycle where vblnk_in is 1 and its previous registered value is 0, so the position never changes mid-frame.
REQ-016 inside SHALL be 1 iff hcount_in >= xpos_l, hcount_in < xpos_l+48, vcount_in >= ypos_l and vcount_in < ypos_l+64, with all compares done in 12-bit unsigned arithmetic so that xpos_l+48 cannot wrap.
REQ-017 Stage 1 (edge 1) SHALL register rom_addr = {y[5:0], x[5:0]} when inside, and 12'h000 otherwise; it SHALL also register inside, rgb_in and all timing inputs.
REQ-018 Stage 2 (edge 2) SHALL delay inside, rgb and timing by one more cycle, aligned with rom_rgb.
REQ-019 Stage 3 (edge 3) SHALL register the outputs; total latency from *_in to *_out SHALL be exactly 3 clk for every signal.
REQ-020 rgb_out SHALL be 12'h000 when the stage-2 hblnk or vblnk is 1, else rom_rgb when stage-2 inside is 1 (subject to REQ-026), else the delayed rgb_in.
REQ-021 A sprite partly off the right or bottom edge SHALL be clipped naturally by REQ-016, with no wrap onto column or row 0.
REQ-022 If the vblnk rising edge and a position change occur in the same cycle, the new xpos/ypos value SHALL be the one latched.

Reset
REQ-023 While rst=1, at each clock edge all pipeline registers, rom_addr and every output SHALL become 0, and the vblnk edge-detect register SHALL become 0.
REQ-024 While rst=1, at each clock edge xpos_l SHALL become XPOS_RST and ypos_l SHALL become YPOS_RST.
REQ-025 Asserting rst mid-frame SHALL flush the pipeline; outputs SHALL be valid again 3 clk after rst falls.

Configuration
REQ-026 With macro DRAW_TANK_TRANSPARENCY_EN defined, inside pixels whose rom_rgb equals KEY_COLOR SHALL output the delayed rgb_in; without the macro, rom_rgb SHALL always be output inside the sprite.

Verification
REQ-027 Reset test: rst held 2 clk with xpos=5 -> all outputs 0; after the first vblnk rise, xpos_l=5; before that rise, xpos_l=100.
REQ-028 Latency test: vsync_in pulse and rgb_in=12'h123 outside the sprite -> vsync_out and rgb_out=12'h123 appear exactly 3 clk later.
REQ-029 Address test: xpos_l=100, ypos_l=100, hcount=147, vcount=163 -> rom_addr=12'hFEF one clk later; hcount=148 -> rom_addr=0 and the background passes through.
REQ-030 Mid-frame move: xpos changes while vblnk=0 -> the drawn position is unchanged until the next vblnk rise; a change coincident with that rise is adopted.
REQ-031 Transparency test: rom_rgb=12'hF0F inside, rgb_in=12'h0A0 -> rgb_out=12'h0A0 with the macro, 12'hF0F without it.
REQ-032 Clipping test: xpos=2030 -> pixels drawn only for hcount 2030..2047, none at hcount 0..29.
